// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whac-a-mole round sequencer: mole timing, hit detection, score and misses
module mole_round_ctrl #(
    parameter int          NUM_MOLES       = 8,
    parameter int          CYCLES_PER_TICK = 1000,
    parameter int          GAP_TICKS       = 4,
    parameter int          UP_TICKS        = 8,
    parameter int          MAX_MISSES      = 3,
    parameter int          SCORE_BITS      = 8,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [NUM_MOLES-1:0]  btn_i,
    output logic [NUM_MOLES-1:0]  mole_o,
    output logic [SCORE_BITS-1:0] score_o,
    output logic [1:0]            misses_o,
    output logic                  hit_pulse_o,
    output logic                  miss_pulse_o,
    output logic                  game_over_o
);

    localparam int POS_W = $clog2(NUM_MOLES);
    localparam int PW    = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
    localparam int MAXT  = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
    localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2,
        S_OVER = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [7:0]            lfsr_q, lfsr_d;
    logic [NUM_MOLES-1:0]  btn_q;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [NUM_MOLES-1:0]  mole_q, mole_d;
    logic [SCORE_BITS-1:0] score_q, score_d;
    logic [1:0]            misses_q, misses_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;
    logic                  over_q, over_d;

    logic                  tick;
    logic                  gap_done;
    logic                  up_done;
    logic [NUM_MOLES-1:0]  btn_edge;
    logic                  target_edge;
    logic [1:0]            misses_inc;
    logic                  last_miss;

    // Shared decode: tick on prescaler terminal count, phase completion, button rising edges
    always_comb begin
        tick        = (pre_q == PW'(CYCLES_PER_TICK - 1));
        gap_done    = tick && (tcnt_q == TW'(GAP_TICKS - 1));
        up_done     = tick && (tcnt_q == TW'(UP_TICKS - 1));
        btn_edge    = btn_i & ~btn_q;
        target_edge = btn_edge[pos_q];
        misses_inc  = misses_q + 2'd1;
        last_miss   = (misses_inc == 2'(MAX_MISSES));
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a hit takes priority over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_i) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_done) state_d = S_UP;
            end
            S_UP: begin
                if (target_edge)  state_d = S_GAP;
                else if (up_done) state_d = last_miss ? S_OVER : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values for the registered outputs
    always_comb begin
        pos_d    = pos_q;
        mole_d   = mole_q;
        score_d  = score_q;
        misses_d = misses_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        over_d   = over_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                mole_d = '0;
                if (start_i) begin
                    score_d  = '0;
                    misses_d = '0;
                    over_d   = 1'b0;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    pos_d  = lfsr_q[POS_W-1:0];
                    mole_d = NUM_MOLES'(1) << lfsr_q[POS_W-1:0];
                end
            end
            S_UP: begin
                if (target_edge) begin
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_BITS'(1);
                    hit_d   = 1'b1;
                    mole_d  = '0;
                end else if (up_done) begin
                    misses_d = misses_inc;
                    miss_d   = 1'b1;
                    mole_d   = '0;
                    if (last_miss) over_d = 1'b1;
                end
            end
            default: mole_d = '0;
        endcase
    end

    // Prescaler and per-state tick counter, both cleared on any state change
    always_comb begin
        pre_d  = pre_q;
        tcnt_d = tcnt_q;
        if (state_d != state_q) begin
            pre_d  = '0;
            tcnt_d = '0;
        end else if (tick) begin
            pre_d = '0;
            if (state_q == S_GAP || state_q == S_UP) tcnt_d = tcnt_q + TW'(1);
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // Datapath and output registers; LFSR and button history update every cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q    <= '0;
            tcnt_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            btn_q    <= '0;
            pos_q    <= '0;
            mole_q   <= '0;
            score_q  <= '0;
            misses_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            tcnt_q   <= tcnt_d;
            lfsr_q   <= lfsr_d;
            btn_q    <= btn_i;
            pos_q    <= pos_d;
            mole_q   <= mole_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            over_q   <= over_d;
        end
    end

    assign mole_o       = mole_q;
    assign score_o      = score_q;
    assign misses_o     = misses_q;
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = miss_q;
    assign game_over_o  = over_q;

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round controller for the whac-a-mole game. It sequences the game datapath: picks a pseudo-random mole position, times the mole's up and gap phases with a tick prescaler, detects hits on the button inputs, and keeps the score and miss count. All outputs are registered and feed the display and score logic directly.

## Interface

- NUM_MOLES, 8, number of mole positions; power of two, 2..8
- CYCLES_PER_TICK, 1000, clock cycles per game tick; ≥1
- GAP_TICKS, 4, ticks with no mole shown between rounds; ≥1
- UP_TICKS, 8, ticks a mole stays up before counting as a miss; ≥1
- MAX_MISSES, 3, misses that end the game; 1..3
- SCORE_BITS, 8, score width; score saturates at 2^SCORE_BITS-1
- LFSR_SEED, 8'hA5, nonzero 8-bit LFSR reset value
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  level, sampled each cycle; begins a game from IDLE or OVER
- btn  in  NUM_MOLES  synchronized, debounced button levels, one per position
- mole  out  NUM_MOLES  one-hot active mole, or 0
- score  out  SCORE_BITS  hits this game
- misses  out  2  misses this game
- hit_pulse  out  1  one-cycle pulse per scored hit
- miss_pulse  out  1  one-cycle pulse per timeout
- game_over  out  1  high while in OVER

## Operation

- Reset (reset=0, asynchronous): state IDLE; mole, score, misses, hit_pulse, miss_pulse and game_over all 0; LFSR=LFSR_SEED; prescaler, tick counter and btn history all 0.
- States: IDLE, GAP, UP, OVER (2-bit encoding).
- IDLE: mole=0. On start=1: clear score and misses, go to GAP.
- GAP: mole=0. After GAP_TICKS ticks, go to UP. Latch pos = lfsr[log2(NUM_MOLES)-1:0] and drive mole = 1<<pos.
- UP, hit: a rising edge on btn[pos] sets score += 1 (saturating), pulses hit_pulse, and goes to GAP with mole=0.
- UP, timeout: after UP_TICKS ticks with no hit, misses += 1 and miss_pulse pulses. If the new misses equals MAX_MISSES, go to OVER; otherwise go to GAP. mole=0 in both cases.
- UP, other buttons: rising edges on non-target buttons are ignored. A button already high when UP is entered produces no edge and does not count.
- OVER: game_over=1, mole=0, score and misses held. start=1 behaves as in IDLE and clears game_over.
- start is ignored in GAP and UP.
- Edge detect: edge = btn & ~btn_q, where btn_q is btn registered every cycle.
- Prescaler: counts 0..CYCLES_PER_TICK-1 and asserts tick on the terminal count. The tick counter counts ticks within the current state. Both clear on every state transition.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in all states, never reaches 0.
- Simultaneous hit and timeout in the same cycle: the hit wins; no miss is recorded.

## Timing

- All outputs are registered. A decision made in cycle t is visible in cycle t+1.
- start=1 in cycle t: state GAP and cleared score/misses are visible at t+1.
- mole goes nonzero at t+1+GAP_TICKS*CYCLES_PER_TICK.
- mole stays up exactly UP_TICKS*CYCLES_PER_TICK cycles unless hit.
- btn[pos] rises in cycle h during UP: mole=0, score updated and hit_pulse=1 in cycle h+1; hit_pulse=0 in cycle h+2.
- A timeout pulses miss_pulse for exactly one cycle, with the same cycle alignment as a hit.
- Reset asserted mid-round: outputs go to their reset values immediately, without waiting for clk. After release the block sits in IDLE until start.

## Test plan

All scenarios use CYCLES_PER_TICK=2, GAP_TICKS=2, UP_TICKS=3, MAX_MISSES=3, SCORE_BITS=2 unless noted.

- Reset, then start pulse at cycle 0 -> score=0, misses=0; mole=0 through cycle 4; mole one-hot at cycle 5 with position = LFSR low bits as predicted by the reference model.
- Mole up, target button rises 1 cycle later -> next cycle mole=0, score=1, hit_pulse high for exactly 1 cycle; mole reappears 4 cycles later.
- No press -> mole high exactly 6 cycles, then miss_pulse for 1 cycle and misses=1. Third miss -> game_over=1, misses=3, mole stays 0 for 50+ cycles. Then start -> game_over=0, score=0, misses=0.
- Wrong button rises during UP -> no score change. Target button held high across GAP->UP -> no hit. Target rises on the final UP cycle -> hit counted, no miss_pulse.
- Four hits with SCORE_BITS=2 -> score reads 1, 2, 3, 3; hit_pulse fires all four times.
- reset driven low mid-UP between clock edges -> mole, score, misses and game_over are 0 before the next clk edge. start pulses during GAP/UP do not restart the round.
